// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture path.
// FSM states, QVGA geometry and RGB565 field layout.
package cam_pkg;

  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_V_ACTIVE = 240;

  typedef logic [1:0] cam_state_t;

  localparam cam_state_t WAIT_SYNC = 2'd0;
  localparam cam_state_t ARMED     = 2'd1;
  localparam cam_state_t CAPTURE   = 2'd2;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  function automatic logic [15:0] rgb565(
    input logic [4:0] r,
    input logic [5:0] g,
    input logic [4:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// cam_byte_pair: pairs camera bytes into 16-bit pixels.
// First byte of a pair lands in [15:8]; pixel_valid marks the second.
module cam_byte_pair (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  cam_data,
  output logic        phase,
  output logic        pixel_valid,
  output logic [15:0] pixel
);

  logic [7:0] hi;

  // latch the high byte and toggle phase on every accepted byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      hi    <= 8'h00;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (en) begin
      if (!phase) hi <= cam_data;
      phase <= ~phase;
    end
  end

  assign pixel_valid = en & phase & ~clear;
  assign pixel       = {hi, cam_data};

endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: captures href/vsync framed camera bytes and
// writes RGB565 pixels at linear addresses into the frame buffer.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = QVGA_H_ACTIVE,
  parameter int V_ACTIVE = QVGA_V_ACTIVE,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  cam_state_t        state;
  logic              vsync_q;
  logic              href_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [YW-1:0]     y_close;
  logic [ADDR_W-1:0] base;

  logic        capturing;
  logic        vsync_rise;
  logic        vsync_fall;
  logic        href_fall;
  logic        frame_start;
  logic        line_close;
  logic        pix_ok;
  logic        wr_fire;
  logic        phase;
  logic        pixel_valid;
  logic [15:0] pixel;

  assign capturing   = (state == CAPTURE);
  assign vsync_rise  = vsync & ~vsync_q;
  assign vsync_fall  = ~vsync & vsync_q;
  assign href_fall   = ~href & href_q;
  assign frame_start = (state == ARMED) & capture_en & vsync_fall;
  assign line_close  = capturing & href_fall;
  assign pix_ok      = (x < X_END) & (y < Y_END);
  assign wr_fire     = capturing & pixel_valid & pix_ok;
  assign busy        = capturing;

  cam_byte_pair u_pair (
    .clk         (clk),
    .reset       (reset),
    .en          (capturing & href),
    .clear       (frame_start | line_close),
    .cam_data    (cam_data),
    .phase       (phase),
    .pixel_valid (pixel_valid),
    .pixel       (pixel)
  );

  // line count as it stands after this cycle's line close
  always_comb begin
    y_close = y;
    if (line_close && x != '0 && y != Y_END)
      y_close = y + 1'b1;
  end

  // one-stage history for edge detection on the pixel clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  // frame gating: only whole frames are ever captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_SYNC;
    end else begin
      case (state)
        WAIT_SYNC: begin
          if (vsync && capture_en) state <= ARMED;
        end
        ARMED: begin
          if (!capture_en)     state <= WAIT_SYNC;
          else if (vsync_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (vsync_rise)
            state <= capture_en ? ARMED : WAIT_SYNC;
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  // pixel/line counters and running line base address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      base <= '0;
    end else if (frame_start) begin
      x    <= '0;
      y    <= '0;
      base <= '0;
    end else if (capturing) begin
      if (pixel_valid && x != X_END) x <= x + 1'b1;
      if (line_close) begin
        x <= '0;
        y <= y_close;
        if (x != '0 && y != Y_END) base <= base + LINE_STEP;
      end
    end
  end

  // registered frame-buffer write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      wAddr <= '0;
      wData <= '0;
    end else begin
      we <= wr_fire;
      if (wr_fire) begin
        wAddr <= base + ADDR_W'(x);
        wData <= pixel;
      end
    end
  end

  // frame completion pulse and sticky framing error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= capturing & vsync_rise;
      if (frame_start) begin
        frame_err <= 1'b0;
      end else if (capturing) begin
        if (line_close && (phase || (x != X_END && y != Y_END)))
          frame_err <= 1'b1;
        if (vsync_rise && y_close != Y_END)
          frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: randomized frames checked against a line-level
// model of which pixels land where, plus done/err/busy expectations.
module tb_cam_frame_writer;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture_en;
  logic          vsync;
  logic          href;
  logic [7:0]    cam_data;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  cam_frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  exp_q[$];
  int   lens[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   done_cnt    = 0;
  int   wr_cnt      = 0;
  logic we_prev     = 1'b0;
  bit   err_state   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int i);
    case (i)
      0:       return 8'hF8;
      1:       return 8'h00;
      2:       return 8'h07;
      default: return 8'hE0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    wr_t e;
    if (we) begin
      wr_cnt++;
      chk("we_b2b", {31'd0, we_prev}, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_we", {31'd0, we}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", {24'd0, wAddr}, e.addr);
        chk("wdata", {16'd0, wData}, e.data);
        chk("we_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) done_cnt++;
    we_prev = we;
  end

  task automatic set_lines(input int n, input int nb);
    lens.delete();
    for (int i = 0; i < n; i++) lens.push_back(nb);
  endtask

  task automatic rand_lines();
    int n;
    n = V - 1 + $urandom_range(0, 2);
    lens.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) lens.push_back(2 * H);
      else lens.push_back(2 * H - 3 + $urandom_range(0, 6));
    end
  endtask

  task automatic run_frame(input bit cap, input int raise_ln,
                           input int drop_ln, input bit sim_end,
                           input int rst_ln, input bit pattern);
    int         y;
    int         d0;
    int         w0;
    int         n_exp;
    int         nb;
    int         np;
    int         kept;
    bit         live;
    bit         ex_cap;
    bit         err;
    logic [7:0] b;
    logic [7:0] b0;
    y      = 0;
    n_exp  = 0;
    b0     = 8'h00;
    live   = cap;
    ex_cap = cap;
    err    = 1'b0;
    d0     = done_cnt;
    w0     = wr_cnt;
    @(negedge clk);
    vsync      = 1'b1;
    href       = 1'b0;
    capture_en = cap;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    vsync = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    for (int l = 0; l < lens.size(); l++) begin
      if (l == raise_ln) capture_en = 1'b1;
      if (l == drop_ln)  capture_en = 1'b0;
      nb   = lens[l];
      np   = nb / 2;
      kept = (np < H) ? np : H;
      for (int i = 0; i < nb; i++) begin
        @(negedge clk);
        if (i == 0) chk("busy", {31'd0, busy}, {31'd0, live});
        if (l == 1 && i == 0)
          chk("err_mid", {31'd0, frame_err},
              {31'd0, live ? err : err_state});
        b = (pattern && l == 0 && i < 4) ? pat_byte(i) : 8'($urandom);
        href     = 1'b1;
        cam_data = b;
        if (i % 2 == 0) begin
          b0 = b;
        end else if (live && y < V && i / 2 < H) begin
          exp_q.push_back('{addr: y * H + i / 2,
                            data: {16'd0, b0, b},
                            cyc:  cyc + 1});
          n_exp++;
        end
        if (l == rst_ln && i == 7 && live) begin
          @(posedge clk);
          #1;
          chk("we_pre_rst", {31'd0, we}, 1);
          reset = 1'b1;
          #1;
          chk("we_rst", {31'd0, we}, 0);
          chk("busy_rst", {31'd0, busy}, 0);
          chk("done_rst", {31'd0, frame_done}, 0);
          chk("err_rst", {31'd0, frame_err}, 0);
          n_exp -= exp_q.size();
          exp_q.delete();
          live   = 1'b0;
          ex_cap = 1'b0;
          err_state = 1'b0;
          @(negedge clk);
          reset = 1'b0;
        end
      end
      @(negedge clk);
      href = 1'b0;
      if (sim_end && l == lens.size() - 1) vsync = 1'b1;
      else repeat ($urandom_range(1, 3)) @(negedge clk);
      if (nb % 2 != 0) err = 1'b1;
      if (kept != H && y < V) err = 1'b1;
      if (np > 0 && y < V) y++;
    end
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    if (y != V) err = 1'b1;
    if (live) err_state = err;
    chk("frame_done", done_cnt - d0, {31'd0, ex_cap});
    chk("frame_err", {31'd0, frame_err}, {31'd0, err_state});
    chk("writes", wr_cnt - w0, n_exp);
  endtask

  initial begin
    reset      = 1'b1;
    capture_en = 1'b0;
    vsync      = 1'b0;
    href       = 1'b0;
    cam_data   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_waddr", {24'd0, wAddr}, 0);
    chk("rst_wdata", {16'd0, wData}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 0, -1, 1);

    set_lines(V, 2 * H);
    lens[0] = 2 * H + 2;
    run_frame(1, -1, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    lens[3] = 2 * H - 1;
    run_frame(1, -1, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(0, 2, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, 3, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(0, -1, -1, 0, -1, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 1, -1, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 0, 5, 0);

    set_lines(V, 2 * H);
    run_frame(1, -1, -1, 0, -1, 0);

    repeat (6) begin
      rand_lines();
      run_frame(1, -1, -1, 1'($urandom_range(0, 1)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
- Write-side counterpart to the QVGA frame-buffer read path: captures an OV7670-style 8-bit parallel pixel stream (href/vsync framing) and writes RGB565 words into the 320x240 frame buffer.
- Pairs two bytes per pixel and generates linear write addresses, y*H_ACTIVE + x.
- Gates capture to whole frames and reports frame completion and framing errors.
- Sits between the camera pins (clocked by PCLK) and the frame buffer write port.

Parameters:
- H_ACTIVE, 320, pixels written per line; excess pixels in a line are dropped.
- V_ACTIVE, 240, lines written per frame; excess lines are dropped.
- ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  input  1  camera pixel clock (PCLK); all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- capture_en  input  1  level; arms capture, evaluated only at frame boundaries.
- vsync  input  1  active-high frame blanking; rising edge marks frame end.
- href  input  1  high while line bytes are valid.
- cam_data  input  8  camera byte.
- we  output  1  frame-buffer write strobe, one cycle per pixel.
- wAddr  output  ADDR_W  write address.
- wData  output  16  RGB565 pixel, first byte in [15:8].
- frame_done  output  1  one-cycle pulse when a captured frame completes.
- frame_err  output  1  sticky framing-error flag; cleared at the next frame start or by reset.
- busy  output  1  high in the CAPTURE state.

Behaviour:
- Reset values: all outputs 0; state WAIT_SYNC; x, y, byte phase and the high-byte register are 0.
- WAIT_SYNC state: wait for vsync=1 (blanking).
  - vsync=1 and capture_en=1 -> ARMED.
  - Never enter CAPTURE mid-frame.
- ARMED state:
  - vsync falling (registered previous vsync=1, current vsync=0) -> CAPTURE.
  - On that transition: x=0, y=0, phase=0, frame_err=0.
  - capture_en=0 while in ARMED -> WAIT_SYNC.
- CAPTURE state:
  - href=1, phase=0: latch cam_data into hi; phase<=1.
  - href=1, phase=1: on the next cycle we=1 and wData={hi,cam_data}.
    - If x<H_ACTIVE and y<V_ACTIVE: wAddr=y*H_ACTIVE+x. Otherwise we stays 0 and the pixel is dropped.
    - phase<=0; x<=x+1, saturating at H_ACTIVE.
  - Write latency is exactly 1 cycle after the second byte is sampled. we is never high two cycles in a row.
  - href falling edge:
    - If x>0, y<=y+1, saturating at V_ACTIVE; x<=0.
    - If phase=1 (odd byte count), the half-byte is discarded, frame_err<=1, phase<=0.
    - If x!=H_ACTIVE and y<V_ACTIVE, frame_err<=1 (short line).
  - vsync rising edge:
    - frame_done pulses for 1 cycle.
    - If y!=V_ACTIVE, frame_err<=1.
    - Next state is ARMED if capture_en=1, else WAIT_SYNC.
    - capture_en deasserted mid-frame does not abort; the frame finishes.
- Address generation: a running base register (base+=H_ACTIVE per line) plus x. No multiplier. Width is ADDR_W, and the address never exceeds H_ACTIVE*V_ACTIVE-1.
- busy = (state==CAPTURE).
- Edge detection uses one register stage each for vsync and href. All edges are evaluated on the same clk.
- Simultaneous href fall and vsync rise: process the line close first (y update, error check), then the frame-end checks, all in the same cycle.
- Reset mid-frame: outputs clear immediately (asynchronous). After release, capture resumes only after a full vsync blank->active sequence.

Decomposition:
- Package cam_pkg holds:
  - the state enum (WAIT_SYNC, ARMED, CAPTURE);
  - the QVGA constants H_ACTIVE=320 and V_ACTIVE=240;
  - the RGB565 field positions R[15:11], G[10:5], B[4:0].
- One sub-module is natural: cam_byte_pair. It handles byte phasing and hi-byte latching and outputs pixel_valid/pixel. The top level owns the FSM, counters and address generation.

Test Plan:
- Reset, then a full frame of 240 lines x 640 bytes with capture_en=1:
  - exactly 76800 writes;
  - first write wAddr=0, last write wAddr=76799;
  - frame_done pulses once at the vsync rise;
  - frame_err=0.
- Line 0 bytes 0xF8,0x00,0x07,0xE0: writes {wAddr=0, wData=16'hF800} and {wAddr=1, wData=16'h07E0}; each we occurs 1 cycle after the second byte.
- Line of 642 bytes (321 pixels): pixel 320 is dropped, with no write at wAddr=320 from line 0. The next line starts at wAddr=320. frame_err=0.
- Line of 639 bytes: the trailing byte is discarded and frame_err=1 until the next frame start. The line's 319 pixels are written.
- capture_en raised while href is active mid-frame: no writes until the following vsync fall. Dropping capture_en mid-frame completes the current frame and then goes to WAIT_SYNC.
- Reset asserted at line 100: we, busy and frame_done go to 0 immediately. After release, the first write is wAddr=0 of the next complete frame.
